// File: rtl/spi_pkg.sv
// Shared SPI target definitions: mode encodings, default word length, synchroniser depth.
// Latency: n/a (constants and a pure helper only).
// Backpressure: n/a.
package spi_pkg;

    // Mode encoding as {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int SPI_DEFAULT_WIDTH = 32;
    localparam int SPI_SYNC_STAGES   = 2;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    function automatic logic mode_cpol(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_cpha(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchroniser for one asynchronous pin into the i_clk domain.
// Latency: SPI_SYNC_STAGES i_clk cycles from pin to o_q.
// Backpressure: none; samples every cycle.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic P_RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [SPI_SYNC_STAGES-1:0] sync_ff;

    // Shift the pin value through the synchroniser chain
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_ff <= {SPI_SYNC_STAGES{P_RST_VAL}};
        end else begin
            sync_ff <= {sync_ff[SPI_SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = sync_ff[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled sck/csn/sdi, LSB-first RX/TX words, runtime CPOL/CPHA.
// Latency: pin edge acted on 3 cycles later; o_rx_valid +1 after that; o_sdo 4 cycles after pin edge.
// Backpressure: single pending TX register gated by o_tx_ready; no RX backpressure (o_rx_data overwritten).
module spi_slave
    import spi_pkg::*;
#(
    parameter int P_WIDTH = SPI_DEFAULT_WIDTH
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_cpol,
    input  logic               i_cpha,
    input  logic               i_sck,
    input  logic               i_csn,
    input  logic               i_sdi,
    output logic               o_sdo,
    output logic               o_sdo_oe,
    input  logic               i_tx_en,
    input  logic [P_WIDTH-1:0] i_tx_data,
    output logic               o_tx_ready,
    output logic [P_WIDTH-1:0] o_rx_data,
    output logic               o_rx_valid,
    output logic               o_tx_underrun,
    output logic               o_busy
);

    localparam int CNT_W = $clog2(P_WIDTH + 1);

    logic sck_s;
    logic csn_s;
    logic sdi_s;
    logic sck_d;
    logic csn_d;

    spi_state_t         state;
    logic [CNT_W-1:0]   bit_cnt;
    logic [P_WIDTH-1:0] rx_shift;
    logic [P_WIDTH-1:0] tx_shift;
    logic [P_WIDTH-1:0] pend_data;
    logic               pend_full;

    logic               csn_fall;
    logic               csn_rise;
    logic               sck_lead;
    logic               sck_trail;
    logic               sel_active;
    logic               sample_edge;
    logic               shift_edge;
    logic               word_done;
    logic               word_start;
    logic               tx_load;
    logic               tx_accept;
    logic [P_WIDTH-1:0] rx_next;

    spi_sync #(.P_RST_VAL(1'b0)) u_sync_sck (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_sck), .o_q(sck_s));
    spi_sync #(.P_RST_VAL(1'b1)) u_sync_csn (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_csn), .o_q(csn_s));
    spi_sync #(.P_RST_VAL(1'b0)) u_sync_sdi (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_sdi), .o_q(sdi_s));

    // Delayed copies of synced sck/csn for edge detection
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_d <= 1'b0;
            csn_d <= 1'b1;
        end else begin
            sck_d <= sck_s;
            csn_d <= csn_s;
        end
    end

    assign csn_fall   = csn_d & ~csn_s;
    assign csn_rise   = ~csn_d & csn_s;
    assign sck_lead   = (sck_d == i_cpol) && (sck_s != i_cpol);
    assign sck_trail  = (sck_d != i_cpol) && (sck_s == i_cpol);
    assign sel_active = (state == ST_ACTIVE) && !csn_s;

    assign sample_edge = sel_active && (i_cpha ? sck_trail : sck_lead);
    assign shift_edge  = sel_active && (i_cpha ? sck_lead : sck_trail);

    assign rx_next    = {sdi_s, rx_shift[P_WIDTH-1:1]};
    assign word_done  = sample_edge && (bit_cnt == CNT_W'(P_WIDTH - 1));
    assign word_start = ((state == ST_IDLE) && csn_fall) || word_done;

    // A write coinciding with a load is taken: the load frees the slot this cycle
    assign tx_load   = word_start && pend_full;
    assign tx_accept = i_tx_en && (!pend_full || tx_load);

    // Pending transmit register and its full flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_full <= 1'b0;
            pend_data <= '0;
        end else if (tx_accept) begin
            pend_full <= 1'b1;
            pend_data <= i_tx_data;
        end else if (tx_load) begin
            pend_full <= 1'b0;
        end
    end

    // Frame FSM with shift registers, bit counter and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            rx_shift      <= '0;
            tx_shift      <= '0;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;
            o_sdo         <= 1'b0;
        end else begin
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (csn_fall) begin
                        state <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (csn_rise) begin
                        // Abort: drop the partial word, keep o_rx_data as is
                        state    <= ST_IDLE;
                        bit_cnt  <= '0;
                        rx_shift <= '0;
                    end else if (sample_edge) begin
                        rx_shift <= rx_next;
                        if (word_done) begin
                            o_rx_data  <= rx_next;
                            o_rx_valid <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (shift_edge && (bit_cnt != '0)) begin
                        // A shift edge with no sample yet in this word is skipped: with
                        // cpha=1 it is the first leading edge (bit 0 already shown), with
                        // cpha=0 it is the tail edge of the previous word after a wrap.
                        tx_shift <= {1'b0, tx_shift[P_WIDTH-1:1]};
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (word_start) begin
                tx_shift      <= pend_full ? pend_data : '0;
                o_tx_underrun <= !pend_full;
                bit_cnt       <= '0;
            end
            o_sdo <= csn_s ? 1'b0 : tx_shift[0];
        end
    end

    assign o_sdo_oe   = ~csn_s;
    assign o_busy     = ~csn_s;
    assign o_tx_ready = ~pend_full;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: table of per-mode frames plus hand-written corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int W = 32;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_cpol;
    logic         i_cpha;
    logic         i_sck;
    logic         i_csn;
    logic         i_sdi;
    logic         o_sdo;
    logic         o_sdo_oe;
    logic         i_tx_en;
    logic [W-1:0] i_tx_data;
    logic         o_tx_ready;
    logic [W-1:0] o_rx_data;
    logic         o_rx_valid;
    logic         o_tx_underrun;
    logic         o_busy;

    always #5 i_clk = ~i_clk;

    spi_slave #(.P_WIDTH(W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_cpol       (i_cpol),
        .i_cpha       (i_cpha),
        .i_sck        (i_sck),
        .i_csn        (i_csn),
        .i_sdi        (i_sdi),
        .o_sdo        (o_sdo),
        .o_sdo_oe     (o_sdo_oe),
        .i_tx_en      (i_tx_en),
        .i_tx_data    (i_tx_data),
        .o_tx_ready   (o_tx_ready),
        .o_rx_data    (o_rx_data),
        .o_rx_valid   (o_rx_valid),
        .o_tx_underrun(o_tx_underrun),
        .o_busy       (o_busy)
    );

    int total = 0;
    int bad   = 0;

    // Pulse monitor: counts o_rx_valid / o_tx_underrun pulses and captures data per pulse
    int           vld_total = 0;
    int           und_total = 0;
    logic [3:0]   vld_ptr   = 4'd0;
    logic [W-1:0] cap    [16];
    logic         und_at [16];

    always @(negedge i_clk) begin
        if (o_rx_valid === 1'b1) begin
            cap[vld_ptr]    = o_rx_data;
            und_at[vld_ptr] = o_tx_underrun;
            vld_ptr         = vld_ptr + 4'd1;
            vld_total       = vld_total + 1;
        end
        if (o_tx_underrun === 1'b1) begin
            und_total = und_total + 1;
        end
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_mode(input logic [1:0] mode);
        @(negedge i_clk);
        i_cpol = mode_cpol(mode);
        i_cpha = mode_cpha(mode);
        i_sck  = mode_cpol(mode);
        repeat (8) @(negedge i_clk);
    endtask

    task automatic tx_write(input logic [W-1:0] d);
        @(negedge i_clk);
        i_tx_en   = 1'b1;
        i_tx_data = d;
        @(negedge i_clk);
        i_tx_en   = 1'b0;
    endtask

    task automatic frame_begin();
        @(negedge i_clk);
        i_csn = 1'b0;
    endtask

    task automatic frame_end();
        repeat (4) @(negedge i_clk);
        i_csn = 1'b1;
        repeat (8) @(negedge i_clk);
    endtask

    // Master side: 4 i_clk per sck phase; MISO read just before the master's sample edge
    task automatic run_bits(input int nbits, input logic [63:0] mosi, output logic [63:0] miso);
        miso = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!i_cpha) begin
                i_sdi = mosi[i];
                repeat (4) @(negedge i_clk);
                miso[i] = o_sdo;
                i_sck   = ~i_cpol;
                repeat (4) @(negedge i_clk);
                i_sck   = i_cpol;
            end else begin
                repeat (4) @(negedge i_clk);
                i_sck = ~i_cpol;
                i_sdi = mosi[i];
                repeat (4) @(negedge i_clk);
                miso[i] = o_sdo;
                i_sck   = i_cpol;
            end
        end
    endtask

    typedef struct {
        logic [1:0]   mode;
        logic [W-1:0] tx_pre;
        logic [W-1:0] mosi;
        logic [W-1:0] exp_rx;
        logic [W-1:0] exp_miso;
    } vec_t;

    localparam int NV = 6;
    vec_t vec [NV];

    initial begin
        logic [63:0] miso;
        int          v0;
        int          u0;
        logic [3:0]  p0;
        logic [1:0]  bb_mode [2];

        vec[0] = '{SPI_MODE0, 32'hA5A5_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hA5A5_1234};
        vec[1] = '{SPI_MODE1, 32'hA5A5_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hA5A5_1234};
        vec[2] = '{SPI_MODE2, 32'hA5A5_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hA5A5_1234};
        vec[3] = '{SPI_MODE3, 32'hA5A5_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hA5A5_1234};
        vec[4] = '{SPI_MODE0, 32'h0000_0001, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h0000_0001};
        vec[5] = '{SPI_MODE3, 32'h8000_0001, 32'h7FFF_FFFE, 32'h7FFF_FFFE, 32'h8000_0001};
        bb_mode[0] = SPI_MODE0;
        bb_mode[1] = SPI_MODE3;

        i_rst     = 1'b1;
        i_cpol    = 1'b0;
        i_cpha    = 1'b0;
        i_sck     = 1'b0;
        i_csn     = 1'b1;
        i_sdi     = 1'b0;
        i_tx_en   = 1'b0;
        i_tx_data = '0;
        repeat (3) @(negedge i_clk);

        chk1 ("rst_sdo",      o_sdo,         1'b0);
        chk1 ("rst_sdo_oe",   o_sdo_oe,      1'b0);
        chk32("rst_rx_data",  o_rx_data,     32'h0);
        chk1 ("rst_rx_valid", o_rx_valid,    1'b0);
        chk1 ("rst_underrun", o_tx_underrun, 1'b0);
        chk1 ("rst_busy",     o_busy,        1'b0);
        chk1 ("rst_tx_ready", o_tx_ready,    1'b1);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        // Single-word frames in each mode; the wrap after the last bit starts an
        // empty word, so each frame ends with exactly one underrun alongside o_rx_valid.
        for (int k = 0; k < NV; k++) begin
            set_mode(vec[k].mode);
            tx_write(vec[k].tx_pre);
            chk1($sformatf("vec%0d_ready_lo", k), o_tx_ready, 1'b0);
            v0 = vld_total;
            u0 = und_total;
            p0 = vld_ptr;
            frame_begin();
            run_bits(W, {32'h0, vec[k].mosi}, miso);
            frame_end();
            chk32($sformatf("vec%0d_rx_data", k), o_rx_data, vec[k].exp_rx);
            chki ($sformatf("vec%0d_valid_cnt", k), vld_total - v0, 1);
            chk32($sformatf("vec%0d_rx_cap", k), cap[p0], vec[k].exp_rx);
            chk32($sformatf("vec%0d_miso", k), miso[31:0], vec[k].exp_miso);
            chk1 ($sformatf("vec%0d_ready_hi", k), o_tx_ready, 1'b1);
            chki ($sformatf("vec%0d_underrun_cnt", k), und_total - u0, 1);
            chk1 ($sformatf("vec%0d_busy_lo", k), o_busy, 1'b0);
            chk1 ($sformatf("vec%0d_oe_lo", k), o_sdo_oe, 1'b0);
        end

        // Back-to-back: two words under one csn, only the first TX word supplied
        for (int m = 0; m < 2; m++) begin
            set_mode(bb_mode[m]);
            tx_write(32'h1357_9BDF);
            v0 = vld_total;
            u0 = und_total;
            p0 = vld_ptr;
            frame_begin();
            run_bits(2 * W, {32'h8000_0000, 32'h0000_0001}, miso);
            frame_end();
            chki ($sformatf("b2b%0d_valid_cnt", m), vld_total - v0, 2);
            chk32($sformatf("b2b%0d_rx0", m), cap[p0], 32'h0000_0001);
            chk32($sformatf("b2b%0d_rx1", m), cap[p0 + 4'd1], 32'h8000_0000);
            chk1 ($sformatf("b2b%0d_underrun_word2", m), und_at[p0], 1'b1);
            chki ($sformatf("b2b%0d_underrun_cnt", m), und_total - u0, 2);
            chk32($sformatf("b2b%0d_miso0", m), miso[31:0], 32'h1357_9BDF);
            chk32($sformatf("b2b%0d_miso1", m), miso[63:32], 32'h0000_0000);
        end

        // Abort after 13 bits: nothing delivered, old o_rx_data kept
        set_mode(SPI_MODE1);
        tx_write(32'h0F0F_0F0F);
        v0 = vld_total;
        frame_begin();
        run_bits(13, {32'h0, 32'h1234_5678}, miso);
        chk1("abort_busy_mid", o_busy, 1'b1);
        chk1("abort_oe_mid", o_sdo_oe, 1'b1);
        frame_end();
        chki ("abort_valid_cnt", vld_total - v0, 0);
        chk32("abort_rx_hold", o_rx_data, 32'h8000_0000);
        chk1 ("abort_ready", o_tx_ready, 1'b1);
        tx_write(32'hCAFE_F00D);
        v0 = vld_total;
        frame_begin();
        run_bits(W, {32'h0, 32'h1234_5678}, miso);
        frame_end();
        chki ("after_abort_valid_cnt", vld_total - v0, 1);
        chk32("after_abort_rx", o_rx_data, 32'h1234_5678);
        chk32("after_abort_miso", miso[31:0], 32'hCAFE_F00D);

        // Handshake: second write while not ready is dropped
        set_mode(SPI_MODE2);
        chk1("hs_ready_init", o_tx_ready, 1'b1);
        tx_write(32'h1111_2222);
        chk1("hs_ready_lo1", o_tx_ready, 1'b0);
        tx_write(32'h3333_4444);
        chk1("hs_ready_lo2", o_tx_ready, 1'b0);
        frame_begin();
        run_bits(W, {32'h0, 32'h5555_AAAA}, miso);
        frame_end();
        chk32("hs_miso", miso[31:0], 32'h1111_2222);
        chk32("hs_rx", o_rx_data, 32'h5555_AAAA);
        chk1 ("hs_ready_hi", o_tx_ready, 1'b1);

        // Reset mid-frame after 10 bits, with a word pending
        set_mode(SPI_MODE1);
        tx_write(32'h7777_8888);
        frame_begin();
        run_bits(10, {32'h0, 32'hFFFF_FFFF}, miso);
        tx_write(32'h9999_AAAA);
        chk1("mrst_ready_lo", o_tx_ready, 1'b0);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk1 ("mrst_sdo",      o_sdo,         1'b0);
        chk1 ("mrst_sdo_oe",   o_sdo_oe,      1'b0);
        chk32("mrst_rx_data",  o_rx_data,     32'h0);
        chk1 ("mrst_rx_valid", o_rx_valid,    1'b0);
        chk1 ("mrst_underrun", o_tx_underrun, 1'b0);
        chk1 ("mrst_busy",     o_busy,        1'b0);
        chk1 ("mrst_tx_ready", o_tx_ready,    1'b1);
        i_csn = 1'b1;
        i_sck = i_cpol;
        repeat (4) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (8) @(negedge i_clk);
        chk1("mrst_busy_after", o_busy, 1'b0);
        tx_write(32'h0BAD_CAFE);
        v0 = vld_total;
        frame_begin();
        run_bits(W, {32'h0, 32'hFEED_0123}, miso);
        frame_end();
        chki ("mrst_next_valid_cnt", vld_total - v0, 1);
        chk32("mrst_next_rx", o_rx_data, 32'hFEED_0123);
        chk32("mrst_next_miso", miso[31:0], 32'h0BAD_CAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
